// File: rtl/wb_dmem_slave.sv
// wb_dmem_slave: Wishbone data-side responder backed by a word-organised RAM
// with byte-lane writes, optional wait states and an error response.
//
// Handshake: a request is taken when cyc_i & stb_i are high at a rising edge
// in IDLE. The responder then owns the request (bus inputs are don't-care
// except cyc_i, which aborts while waiting). Completion is a one-cycle pulse
// on exactly one of ack_o / err_o. The master drops stb on that pulse, and no
// new request is taken in the RESP cycle.
module wb_dmem_slave #(
    parameter int DEPTH       = 1024,
    parameter int AW          = 32,
    parameter int WAIT_STATES = 0
) (
    input  logic          clk_i,
    input  logic          rstn_i,
    input  logic          wbs_cyc_i,
    input  logic          wbs_stb_i,
    input  logic          wbs_we_i,
    input  logic [AW-1:0] wbs_adr_i,
    input  logic [31:0]   wbs_dat_i,
    input  logic [3:0]    wbs_sel_i,
    output logic [31:0]   wbs_dat_o,
    output logic          wbs_ack_o,
    output logic          wbs_err_o
);

    localparam int IW  = AW - 2;
    localparam int AIW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IW:0] DEPTH_W  = (IW + 1)'(DEPTH);
    localparam logic [3:0]  CNT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t         state, state_next;
    logic [3:0]     cnt, cnt_next;
    logic [IW-1:0]  req_adr;
    logic [31:0]    req_dat;
    logic [3:0]     req_sel;
    logic           req_we;
    logic           ack, err;
    logic [31:0]    dat;

    logic           capture, enter_resp;
    logic [IW-1:0]  eff_adr;
    logic [31:0]    eff_dat;
    logic [3:0]     eff_sel;
    logic           eff_we;
    logic           bad;
    logic [AIW-1:0] idx;

    logic [31:0]    mem [DEPTH];

    // Byte offset bits never select anything in a word-organised store.
    logic unused_adr_lsb;
    assign unused_adr_lsb = ^wbs_adr_i[1:0];

    // Request being answered: live bus when answering straight from IDLE, else the captured copy.
    always_comb begin
        eff_adr = req_adr;
        eff_dat = req_dat;
        eff_sel = req_sel;
        eff_we  = req_we;
        if (state == S_IDLE) begin
            eff_adr = wbs_adr_i[AW-1:2];
            eff_dat = wbs_dat_i;
            eff_sel = wbs_sel_i;
            eff_we  = wbs_we_i;
        end
        bad = ({1'b0, eff_adr} >= DEPTH_W) || (eff_sel == 4'b0000);
        idx = eff_adr[AIW-1:0];
    end

    // Next-state logic: capture in IDLE, count down in WAIT, single-cycle RESP.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        capture    = 1'b0;
        enter_resp = 1'b0;
        case (state)
            S_IDLE: begin
                if (wbs_cyc_i && wbs_stb_i) begin
                    capture = 1'b1;
                    if (WAIT_STATES == 0) begin
                        state_next = S_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_next = S_WAIT;
                        cnt_next   = CNT_INIT;
                    end
                end
            end
            S_WAIT: begin
                if (!wbs_cyc_i) begin
                    state_next = S_IDLE;
                end else if (cnt == 4'd0) begin
                    state_next = S_RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end
            S_RESP:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // State, request capture and registered response outputs.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state   <= S_IDLE;
            cnt     <= 4'd0;
            req_adr <= '0;
            req_dat <= '0;
            req_sel <= '0;
            req_we  <= 1'b0;
            ack     <= 1'b0;
            err     <= 1'b0;
            dat     <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            ack   <= enter_resp && !bad;
            err   <= enter_resp && bad;
            if (capture) begin
                req_adr <= wbs_adr_i[AW-1:2];
                req_dat <= wbs_dat_i;
                req_sel <= wbs_sel_i;
                req_we  <= wbs_we_i;
            end
            if (enter_resp && bad) begin
                dat <= '0;
            end else if (enter_resp && !eff_we) begin
                dat <= mem[idx];
            end
        end
    end

    // RAM write commits on the edge entering RESP; held off while reset is asserted.
    always_ff @(posedge clk_i) begin
        if (rstn_i && enter_resp && eff_we && !bad) begin
            for (int b = 0; b < 4; b++) begin
                if (eff_sel[b]) begin
                    mem[idx][8*b +: 8] <= eff_dat[8*b +: 8];
                end
            end
        end
    end

    assign wbs_dat_o = dat;
    assign wbs_ack_o = ack;
    assign wbs_err_o = err;

endmodule

// File: tb/tb_wb_dmem_slave.sv
// Directed bench for wb_dmem_slave: one instance with no wait states, one with three.
module tb_wb_dmem_slave;

  localparam int DEPTH = 64;
  localparam int AW    = 32;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn = 1'b1;
  logic        cyc0 = 1'b0, cyc1 = 1'b0, stb = 1'b0, we = 1'b0;
  logic [31:0] adr = '0, wdat = '0;
  logic [3:0]  sel = '0;
  logic [31:0] dat0, dat1;
  logic        ack0, ack1, err0, err1;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  wb_dmem_slave #(.DEPTH(DEPTH), .AW(AW), .WAIT_STATES(0)) dut0 (
    .clk_i(clk), .rstn_i(rstn), .wbs_cyc_i(cyc0), .wbs_stb_i(stb), .wbs_we_i(we),
    .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_sel_i(sel),
    .wbs_dat_o(dat0), .wbs_ack_o(ack0), .wbs_err_o(err0)
  );

  wb_dmem_slave #(.DEPTH(DEPTH), .AW(AW), .WAIT_STATES(3)) dut1 (
    .clk_i(clk), .rstn_i(rstn), .wbs_cyc_i(cyc1), .wbs_stb_i(stb), .wbs_we_i(we),
    .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_sel_i(sel),
    .wbs_dat_o(dat1), .wbs_ack_o(ack1), .wbs_err_o(err1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic ack_of(input int d);
    return (d == 0) ? ack0 : ack1;
  endfunction

  function automatic logic err_of(input int d);
    return (d == 0) ? err0 : err1;
  endfunction

  function automatic logic [31:0] dat_of(input int d);
    return (d == 0) ? dat0 : dat1;
  endfunction

  // driver tasks
  task automatic drive_req(input int d, input logic w, input logic [31:0] a,
                           input logic [31:0] v, input logic [3:0] s);
    cyc0 = (d == 0);
    cyc1 = (d == 1);
    stb  = 1'b1;
    we   = w;
    adr  = a;
    wdat = v;
    sel  = s;
  endtask

  task automatic idle_bus();
    cyc0 = 1'b0;
    cyc1 = 1'b0;
    stb  = 1'b0;
  endtask

  task automatic bus_txn(input int d, input logic w, input logic [31:0] a,
                         input logic [31:0] v, input logic [3:0] s,
                         output logic [31:0] rd, output logic ok, output logic bad,
                         output int lat);
    @(negedge clk);
    drive_req(d, w, a, v, s);
    lat = -1;
    ok  = 1'b0;
    bad = 1'b0;
    rd  = '0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (ack_of(d) || err_of(d)) begin
        ok  = ack_of(d);
        bad = err_of(d);
        rd  = dat_of(d);
        lat = i;
        break;
      end
    end
    idle_bus();
    @(negedge clk);
    check("pulse_end", {30'b0, ack_of(d), err_of(d)}, 32'h0);
  endtask

  task automatic write_ok(input int d, input logic [31:0] a, input logic [31:0] v,
                          input logic [3:0] s, input int ws);
    logic [31:0] rd, prev;
    logic ok, bad;
    int lat;
    prev = dat_of(d);
    bus_txn(d, 1'b1, a, v, s, rd, ok, bad, lat);
    check("wr_ack", {31'b0, ok}, 32'h1);
    check("wr_err", {31'b0, bad}, 32'h0);
    check("wr_lat", 32'(lat), 32'(ws + 1));
    check("wr_dat_hold", rd, prev);
  endtask

  task automatic read_ok(input int d, input logic [31:0] a, input logic [31:0] expv, input int ws);
    logic [31:0] rd;
    logic ok, bad;
    int lat;
    exp_q.push_back(expv);
    bus_txn(d, 1'b0, a, 32'h0, 4'b1111, rd, ok, bad, lat);
    check("rd_ack", {31'b0, ok}, 32'h1);
    check("rd_lat", 32'(lat), 32'(ws + 1));
    check("rd_data", rd, exp_q.pop_front());
  endtask

  task automatic err_txn(input int d, input logic w, input logic [31:0] a,
                         input logic [31:0] v, input logic [3:0] s);
    logic [31:0] rd;
    logic ok, bad;
    int lat;
    bus_txn(d, w, a, v, s, rd, ok, bad, lat);
    check("err_ack", {31'b0, ok}, 32'h0);
    check("err_err", {31'b0, bad}, 32'h1);
    check("err_dat", rd, 32'h0);
  endtask

  initial begin
    int seen;

    // Asynchronous reset mid-cycle
    #3 rstn = 1'b0;
    #1;
    check("rst_out0", {dat0[29:0], ack0, err0}, 32'h0);
    check("rst_out1", {dat1[29:0], ack1, err1}, 32'h0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;

    // Full-word write then read, no wait states
    write_ok(0, 32'h10, 32'hDEADBEEF, 4'b1111, 0);
    read_ok(0, 32'h10, 32'hDEADBEEF, 0);
    read_ok(0, 32'h13, 32'hDEADBEEF, 0);

    // Byte and half-word lanes
    write_ok(0, 32'h20, 32'h11223344, 4'b1111, 0);
    write_ok(0, 32'h20, 32'h000000AA, 4'b0001, 0);
    read_ok(0, 32'h20, 32'h112233AA, 0);
    write_ok(0, 32'h20, 32'h0000BBCC, 4'b0011, 0);
    read_ok(0, 32'h20, 32'h1122BBCC, 0);
    write_ok(0, 32'h20, 32'hA5B60000, 4'b1100, 0);
    read_ok(0, 32'h20, 32'hA5B6BBCC, 0);

    // Last valid word and out-of-range errors
    write_ok(0, 32'h0, 32'h01020304, 4'b1111, 0);
    write_ok(0, DEPTH * 4 - 4, 32'hFEEDFACE, 4'b1111, 0);
    read_ok(0, DEPTH * 4 - 4, 32'hFEEDFACE, 0);
    err_txn(0, 1'b0, DEPTH * 4, 32'h0, 4'b1111);
    err_txn(0, 1'b1, DEPTH * 4, 32'h99999999, 4'b1111);
    read_ok(0, 32'h0, 32'h01020304, 0);
    err_txn(0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000);
    read_ok(0, 32'h20, 32'hA5B6BBCC, 0);

    // Strobe without cycle is ignored
    @(negedge clk);
    stb = 1'b1;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (ack0 || err0 || ack1 || err1) seen++;
    end
    stb = 1'b0;
    check("stb_no_cyc", 32'(seen), 32'h0);

    // Wait states
    write_ok(1, 32'h30, 32'hCAFEF00D, 4'b1111, 3);
    read_ok(1, 32'h30, 32'hCAFEF00D, 3);
    write_ok(1, 32'h0, 32'h00000000, 4'b1111, 3);

    // Abort by dropping cyc during WAIT
    @(negedge clk);
    drive_req(1, 1'b1, 32'h0, 32'h55555555, 4'b1111);
    repeat (2) @(negedge clk);
    cyc1 = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (ack1 || err1) seen++;
    end
    idle_bus();
    check("abort_quiet", 32'(seen), 32'h0);
    read_ok(1, 32'h0, 32'h00000000, 3);

    // Reset pulsed during WAIT
    read_ok(1, 32'h30, 32'hCAFEF00D, 3);
    @(negedge clk);
    drive_req(1, 1'b1, 32'h0, 32'h55555555, 4'b1111);
    repeat (2) @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    check("rst_wait_out", {dat1[29:0], ack1, err1}, 32'h0);
    @(negedge clk);
    idle_bus();
    rstn = 1'b1;
    read_ok(1, 32'h0, 32'h00000000, 3);
    write_ok(1, 32'h4, 32'h13572468, 4'b1111, 3);
    read_ok(1, 32'h4, 32'h13572468, 3);

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
